uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Grant in IDLE, one-cycle tx_start, wait for tx_done or timeout, then an idle gap.
module uart_tx_arbiter #(
   parameter int N_REQ          = 4,
   parameter int GAP_CYCLES     = 10415,
   parameter int TIMEOUT_CYCLES = 120000
) (
   input  logic                      clk_100MHz,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [8*N_REQ-1:0]        req_data,
   output logic [N_REQ-1:0]          ack,
   output logic [N_REQ-1:0]          done,
   output logic                      tx_start,
   output logic [7:0]                tx_data,
   input  logic                      tx_done,
   output logic [$clog2(N_REQ)-1:0]  owner,
   output logic                      busy,
   output logic                      timeout_err
);
   localparam int OW   = $clog2(N_REQ);
   localparam int MAXC = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [OW-1:0] LAST_INIT = OW'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [OW-1:0]     last_grant, last_nxt;
   logic [N_REQ-1:0]  ack_nxt, done_nxt;
   logic              tx_start_nxt, tmo_nxt, busy_nxt;
   logic [7:0]        tx_data_nxt, gnt_dat;
   logic [OW-1:0]     owner_nxt, gnt, cand;
   logic              found;
   int                idx;

   // Round-robin search starting just after the previous grant.
   always_comb begin
      found   = 1'b0;
      gnt     = '0;
      cand    = '0;
      idx     = 0;
      gnt_dat = 8'h00;
      for (int k = 1; k <= N_REQ; k++) begin
         idx  = (int'(last_grant) + k) % N_REQ;
         cand = OW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            gnt   = cand;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (found && OW'(i) == gnt) gnt_dat = req_data[i*8 +: 8];
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      last_nxt     = last_grant;
      ack_nxt      = '0;
      done_nxt     = '0;
      tx_start_nxt = 1'b0;
      tmo_nxt      = 1'b0;
      tx_data_nxt  = tx_data;
      owner_nxt    = owner;
      case (state)
         IDLE: begin
            if (found) begin
               ack_nxt[gnt] = 1'b1;
               tx_data_nxt  = gnt_dat;
               owner_nxt    = gnt;
               last_nxt     = gnt;
               state_nxt    = LOAD;
            end
         end
         LOAD: begin
            tx_start_nxt = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = WAIT_DONE;
         end
         WAIT_DONE: begin
            // Completion wins over a timeout expiring on the same edge.
            if (tx_done) begin
               done_nxt[owner] = 1'b1;
               cnt_nxt         = GAP_LOAD;
               state_nxt       = GAP;
            end else if (cnt == TMO_LAST) begin
               tmo_nxt   = 1'b1;
               cnt_nxt   = GAP_LOAD;
               state_nxt = GAP;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         GAP: begin
            if (cnt <= CNT_ONE) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         last_grant  <= LAST_INIT;
         ack         <= '0;
         done        <= '0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         owner       <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         last_grant  <= last_nxt;
         ack         <= ack_nxt;
         done        <= done_nxt;
         tx_start    <= tx_start_nxt;
         tx_data     <= tx_data_nxt;
         owner       <= owner_nxt;
         busy        <= busy_nxt;
         timeout_err <= tmo_nxt;
      end
   end
endmodule
